// File: rtl/led_fader.sv
// Per-channel LED fader: each output ramps its PWM brightness one level
// per step toward full-on or full-off, following the upstream on/off request.
module led_fader #(
    parameter int N_LED    = 18,
    parameter int PWM_BITS = 4,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_LED-1:0] led_in,
    output logic [N_LED-1:0] led_out,
    output logic             busy,
    output logic             step_tick
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0]             pwm_cnt;
    logic [DIV_W-1:0]                div_cnt;
    logic [N_LED-1:0]                req;
    logic [N_LED-1:0][PWM_BITS-1:0]  level;
    logic                            pwm_wrap;
    logic                            step;

    assign pwm_wrap = (pwm_cnt == MAX);
    assign step     = pwm_wrap && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            div_cnt   <= '0;
            step_tick <= 1'b0;
            req       <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            step_tick <= step;
            req       <= led_in;
            if (pwm_wrap) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end
        end
    end

    // Levels saturate at both ends, so a reversal just flips the direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= '0;
            led_out <= '0;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                led_out[i] <= (level[i] == MAX) || (pwm_cnt < level[i]);
                if (step) begin
                    if (req[i] && level[i] != MAX) begin
                        level[i] <= level[i] + 1'b1;
                    end else if (!req[i] && level[i] != '0) begin
                        level[i] <= level[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_LED; i++) begin
            if (level[i] != (req[i] ? MAX : '0)) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 The block SHALL provide parameter N_LED, default 18, giving the number of LED channels.
REQ-002 The block SHALL provide parameter PWM_BITS, default 4, giving the brightness resolution; legal range is 2..8.
REQ-003 The block SHALL provide parameter STEP_DIV, default 4, giving the number of PWM periods per brightness step; legal range is >=1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port led_in, input, N_LED bits: on/off requests from the upstream blink pattern generator; bit i corresponds to led<i>.
REQ-007 The block SHALL have port led_out, output, N_LED bits: PWM-faded drive to the physical LEDs, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any channel's level differs from its target.
REQ-009 The block SHALL have port step_tick, output, 1 bit: registered one-cycle pulse marking each brightness step.

Function
REQ-010 The block SHALL define MAX = 2^PWM_BITS - 1.
REQ-011 The block SHALL run a free-running counter pwm_cnt of PWM_BITS bits, incrementing every cycle and wrapping from MAX to 0, giving a PWM period of 2^PWM_BITS cycles.
REQ-012 The block SHALL run counter div_cnt over 0..STEP_DIV-1, advancing on every cycle where pwm_cnt==MAX and wrapping to 0 after STEP_DIV-1.
REQ-013 The internal step condition SHALL be pwm_cnt==MAX && div_cnt==STEP_DIV-1; step_tick SHALL be the registered copy of this condition, high for exactly the cycle following it.
REQ-014 led_in SHALL be registered into req[N_LED-1:0] every cycle (one-cycle input latency); no other filtering SHALL be applied.
REQ-015 Each channel SHALL hold level[i] (PWM_BITS bits), with target[i] = MAX when req[i]=1 and 0 otherwise.
REQ-016 On the edge where the step condition is true, level[i] SHALL increment by 1 if req[i]=1 and level[i]<MAX, decrement by 1 if req[i]=0 and level[i]>0, and otherwise hold; level SHALL never wrap.
REQ-017 Levels SHALL change only on step edges; req values between step edges SHALL have no effect, so a pulse on led_in that is not sampled into req at a step edge is ignored.
REQ-018 Each edge SHALL compute led_out[i] <= (level[i]==MAX) || (pwm_cnt < level[i]) from current register values, giving a duty of level/2^PWM_BITS for level<MAX and 100% at MAX.
REQ-019 A direction reversal mid-ramp SHALL take effect at the next step edge with no skipped or repeated level.
REQ-020 busy SHALL equal the OR over all channels of (level[i] != target[i]), decoded from registers only.
REQ-021 Channels SHALL be fully independent; any mix of simultaneous rising and falling requests SHALL update all channels on the same step edge.

Reset
REQ-022 While rst=1, the block SHALL asynchronously force pwm_cnt=0, div_cnt=0, req=0, all level=0, led_out=0, step_tick=0, and busy=0.
REQ-023 After rst deasserts, pwm_cnt SHALL read 0 on the first rising edge and 1 after it, so the first step condition occurs 2^PWM_BITS*STEP_DIV-1 cycles after release (63 at defaults).
REQ-024 Reset asserted mid-ramp SHALL discard all levels; no ramp SHALL resume after release until re-requested by led_in.

Verification (defaults: period 16 cycles, step every 64 cycles, full ramp 15 steps = 960 cycles)
REQ-025 Idle: hold rst for 2 cycles, release with led_in=0, run 2000 cycles -> led_out=0, busy=0, step_tick pulses every 64 cycles.
REQ-026 Fade-in: set led_in[0]=1 at release.
  - busy=1 from cycle 2.
  - level0=1 after the first step; led_out[0] then high 1 cycle of every 16.
  - After 15 steps (~960 cycles), led_out[0] is constantly 1 and busy=0.
  - All other led_out bits stay 0.
REQ-027 Fade-out and reversal:
  - From full brightness, clear led_in[0] -> duty falls 14/16, 13/16, ... to 0 over 15 steps.
  - Re-assert led_in[0] at level 5 -> next step gives level 6.
REQ-028 Glitch rejection: drive a 10-cycle pulse on led_in[3] placed wholly between two step edges -> level3 stays 0, led_out[3] stays 0, step_tick cadence unchanged.
REQ-029 Async reset mid-ramp: 18 channels are ramping at level 7; assert rst between clock edges -> led_out=0 and busy=0 before the next edge; after release with led_in=0, everything stays 0.
REQ-030 All channels: drive led_in=all-ones -> all 18 led_out bits are identical every cycle and reach constant 1 together after 15 steps.
